// File: rtl/core_pkg.sv
// Shared pipeline types for the RV32I core.
// Holds the inter-stage bundles, funct3 codes and the LSU state set.
package core_pkg;

  typedef struct packed {
    logic       register_write;
    logic [1:0] result_src;
    logic       mem_store;
    logic       mem_load;
  } ctrl_t;

  typedef struct packed {
    logic [31:0] alu_result;
    logic [31:0] write_data;
    logic [4:0]  rd;
    logic [31:0] pc_inc;
    ctrl_t       ctrl;
  } exe_mem_inf_t;

  typedef struct packed {
    logic [31:0] alu_result;
    logic [31:0] read_data;
    logic [4:0]  rd;
    logic [31:0] pc_inc;
    logic        register_write;
    logic [1:0]  result_src;
  } mem_wb_inf_t;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    RSP,
    DONE
  } lsu_state_e;

endpackage

// File: rtl/lsu_align.sv
// Byte-lane steering for the memory stage: store enables/data
// replication and load lane extraction with sign/zero extension.
module lsu_align
  import core_pkg::*;
(
  input  logic [2:0]  funct3,
  input  logic [1:0]  off,
  input  logic [31:0] store_data,
  input  logic [31:0] load_word,
  output logic [3:0]  be,
  output logic [31:0] wdata,
  output logic [31:0] load_data
);

  logic        is_b;
  logic        is_h;
  logic [7:0]  lane_b;
  logic [15:0] lane_h;

  assign is_b   = (funct3[1:0] == 2'b00);
  assign is_h   = (funct3[1:0] == 2'b01);
  assign lane_b = load_word[{off, 3'b000} +: 8];
  assign lane_h = off[1] ? load_word[31:16]
                         : load_word[15:0];

  always_comb begin
    be    = 4'b1111;
    wdata = store_data;
    unique case (1'b1)
      is_b: begin
        be    = 4'b0001 << off;
        wdata = {4{store_data[7:0]}};
      end
      is_h: begin
        be    = 4'b0011 << {off[1], 1'b0};
        wdata = {2{store_data[15:0]}};
      end
      default: ;
    endcase
  end

  always_comb begin
    load_data = load_word;
    unique case (1'b1)
      (funct3 == F3_LB):
        load_data = {{24{lane_b[7]}}, lane_b};
      (funct3 == F3_LH):
        load_data = {{16{lane_h[15]}}, lane_h};
      (funct3 == F3_LBU):
        load_data = {24'h0, lane_b};
      (funct3 == F3_LHU):
        load_data = {16'h0, lane_h};
      default: ;
    endcase
  end

endmodule

// File: rtl/mem_lsu.sv
// Memory stage: issues loads/stores on the data bus and stalls until done.
// Define MISALIGN_TRAP_EN to skip misaligned accesses and flag them.
module mem_lsu
  import core_pkg::*;
#(
  parameter int ADDR_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  exe_mem_inf_t          exe_mem_inf,
  input  logic [2:0]            mem_funct3,
  output logic [31:0]           mem_alu_result,
  output logic                  stall,
  output logic                  dbus_req_valid,
  input  logic                  dbus_req_ready,
  output logic [ADDR_WIDTH-1:0] dbus_addr,
  output logic                  dbus_we,
  output logic [3:0]            dbus_be,
  output logic [31:0]           dbus_wdata,
  input  logic                  dbus_rsp_valid,
  input  logic [31:0]           dbus_rdata,
`ifdef MISALIGN_TRAP_EN
  output logic                  misaligned,
`endif
  output mem_wb_inf_t           mem_wb_inf
);

  lsu_state_e  state_q;
  lsu_state_e  state_d;
  logic        pending;
  logic        is_load;
  logic        misal;
  logic        trap_retire;
  logic [1:0]  off;
  logic [3:0]  be;
  logic [31:0] load_data;
  logic [31:0] load_q;

  assign off     = exe_mem_inf.alu_result[1:0];
  assign is_load = exe_mem_inf.ctrl.mem_load;
  assign pending = exe_mem_inf.ctrl.mem_load
                 | exe_mem_inf.ctrl.mem_store;

  assign mem_alu_result = exe_mem_inf.alu_result;

`ifdef MISALIGN_TRAP_EN
  assign misal = pending
               & (((mem_funct3[1:0] == 2'b01) & off[0])
               |  (mem_funct3[1] & (off != 2'b00)));
`else
  assign misal = 1'b0;
`endif

  assign trap_retire = (state_q == DONE) & misal;

  lsu_align u_align (
    .funct3     (mem_funct3),
    .off        (off),
    .store_data (exe_mem_inf.write_data),
    .load_word  (dbus_rdata),
    .be         (be),
    .wdata      (dbus_wdata),
    .load_data  (load_data)
  );

  assign dbus_addr = {exe_mem_inf.alu_result[ADDR_WIDTH-1:2], 2'b00};
  assign dbus_we   = dbus_req_valid & ~is_load;
  assign dbus_be   = dbus_req_valid ? be : 4'b0000;

  always_comb begin
    state_d        = state_q;
    stall          = 1'b0;
    dbus_req_valid = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (pending) begin
          stall   = 1'b1;
          state_d = misal ? DONE : REQ;
        end
      end
      REQ: begin
        stall          = 1'b1;
        dbus_req_valid = 1'b1;
        if (dbus_req_ready) begin
          state_d = is_load ? RSP : DONE;
        end
      end
      RSP: begin
        stall = 1'b1;
        if (dbus_rsp_valid) begin
          state_d = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      load_q     <= '0;
      mem_wb_inf <= '0;
    end else begin
      state_q <= state_d;
      // Responses outside RSP belong to abandoned accesses.
      if (state_q == RSP && dbus_rsp_valid) begin
        load_q <= load_data;
      end
      mem_wb_inf.alu_result     <= exe_mem_inf.alu_result;
      mem_wb_inf.read_data      <= load_q;
      mem_wb_inf.rd             <= exe_mem_inf.rd;
      mem_wb_inf.pc_inc         <= exe_mem_inf.pc_inc;
      mem_wb_inf.result_src     <= exe_mem_inf.ctrl.result_src;
      mem_wb_inf.register_write <= exe_mem_inf.ctrl.register_write
                                 & ~stall & ~trap_retire;
    end
  end

`ifdef MISALIGN_TRAP_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      misaligned <= 1'b0;
    end else begin
      misaligned <= trap_retire;
    end
  end
`endif

endmodule

// File: tb/tb_mem_lsu.sv
// Self-checking bench for mem_lsu: directed scenarios plus a randomized
// op stream compared against a byte-addressed memory reference.
module tb_mem_lsu;
  import core_pkg::*;

  logic         clk = 1'b0;
  logic         rst;
  exe_mem_inf_t exe;
  logic [2:0]   f3;
  logic [31:0]  fwd;
  logic         stall;
  logic         req_valid;
  logic         req_ready;
  logic [31:0]  addr;
  logic         we;
  logic [3:0]   be;
  logic [31:0]  wdata;
  logic         rsp_valid;
  logic [31:0]  rdata;
  mem_wb_inf_t  wb;

  int checks = 0;
  int passed = 0;

  logic [31:0] bus_mem [16];
  logic [7:0]  ref_mem [64];

  int          obs_stall;
  int          obs_hs;
  int          obs_retire;
  int          obs_retire_cyc;
  int          obs_first_req;
  bit          obs_stable;
  bit          obs_timeout;
  logic [31:0] obs_addr;
  logic [31:0] obs_wdata;
  logic [3:0]  obs_be;
  logic        obs_we;
  logic [31:0] obs_fwd;
  mem_wb_inf_t obs_wb;

  mem_lsu #(.ADDR_WIDTH(32)) dut (
    .clk            (clk),
    .rst            (rst),
    .exe_mem_inf    (exe),
    .mem_funct3     (f3),
    .mem_alu_result (fwd),
    .stall          (stall),
    .dbus_req_valid (req_valid),
    .dbus_req_ready (req_ready),
    .dbus_addr      (addr),
    .dbus_we        (we),
    .dbus_be        (be),
    .dbus_wdata     (wdata),
    .dbus_rsp_valid (rsp_valid),
    .dbus_rdata     (rdata),
    .mem_wb_inf     (wb)
  );

  always #5 clk = ~clk;

  // Presents one op, plays the bus slave, records what the DUT did.
  task automatic run_op(input exe_mem_inf_t op, input logic [2:0] fn,
                        input int rdly, input int sdly);
    int  wait_cnt;
    int  rsp_cnt;
    bit  armed;
    bit  done;
    bit  seen;
    obs_stall = 0; obs_hs = 0; obs_retire = 0;
    obs_retire_cyc = -1; obs_first_req = -1;
    obs_stable = 1; obs_timeout = 0; obs_wb = '0;
    obs_addr = '0; obs_wdata = '0; obs_be = '0; obs_we = 0;
    wait_cnt = 0; rsp_cnt = 0; armed = 0; done = 0; seen = 0;
    @(negedge clk);
    exe = op;
    f3  = fn;
    for (int c = 0; c < 40 && !done; c++) begin
      #1;
      rsp_valid = 0;
      if (armed) begin
        if (rsp_cnt == 0) begin
          rsp_valid = 1;
          rdata = bus_mem[obs_addr[5:2]];
          armed = 0;
        end else begin
          rsp_cnt--;
        end
      end
      if (c == 0) obs_fwd = fwd;
      if (req_valid) begin
        if (obs_first_req < 0) obs_first_req = c;
        if (!seen) begin
          obs_addr = addr; obs_wdata = wdata;
          obs_be = be; obs_we = we; seen = 1;
        end else if (addr !== obs_addr || wdata !== obs_wdata ||
                     be !== obs_be || we !== obs_we) begin
          obs_stable = 0;
        end
        req_ready = (wait_cnt >= rdly);
        wait_cnt++;
      end else begin
        req_ready = 0;
      end
      #1;
      if (stall) obs_stall++;
      else done = 1;
      if (req_valid && req_ready) begin
        obs_hs++;
        if (we) begin
          for (int b = 0; b < 4; b++)
            if (be[b]) bus_mem[addr[5:2]][8*b +: 8] = wdata[8*b +: 8];
        end else begin
          armed = 1;
          rsp_cnt = sdly;
        end
      end
      @(posedge clk);
      #1;
      if (wb.register_write) begin
        obs_retire++;
        obs_retire_cyc = c;
        obs_wb = wb;
      end
      if (!done) @(negedge clk);
    end
    if (!done) obs_timeout = 1;
    exe = '0;
    req_ready = 0;
    rsp_valid = 0;
  endtask

  task automatic test_reset();
    exe = '0;
    exe.alu_result = 32'h77;
    exe.ctrl.register_write = 1;
    exe.ctrl.result_src = 2'd2;
    rst = 1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 0;
    exe = '0;
    #1;
    checks++;
    if (stall !== 1'b0) $display("FAIL reset_stall got %b exp 0", stall);
    else passed++;
    checks++;
    if (req_valid !== 1'b0) $display("FAIL reset_req_valid got %b exp 0", req_valid);
    else passed++;
    checks++;
    if (we !== 1'b0) $display("FAIL reset_we got %b exp 0", we);
    else passed++;
    checks++;
    if (be !== 4'b0) $display("FAIL reset_be got %b exp 0000", be);
    else passed++;
    checks++;
    if (wb.register_write !== 1'b0)
      $display("FAIL reset_regwrite got %b exp 0", wb.register_write);
    else passed++;
    checks++;
    if (wb.result_src !== 2'd0)
      $display("FAIL reset_result_src got %0d exp 0", wb.result_src);
    else passed++;
  endtask

  task automatic test_alu_op();
    exe_mem_inf_t op;
    op = '0;
    op.alu_result = 32'h1234;
    op.rd = 5'd5;
    op.pc_inc = 32'h40;
    op.ctrl.register_write = 1;
    run_op(op, F3_LW, 0, 0);
    checks++;
    if (obs_stall !== 0) $display("FAIL alu_stall got %0d exp 0", obs_stall);
    else passed++;
    checks++;
    if (obs_fwd !== 32'h1234) $display("FAIL alu_fwd got %h exp 00001234", obs_fwd);
    else passed++;
    checks++;
    if (obs_hs !== 0) $display("FAIL alu_bus got %0d exp 0", obs_hs);
    else passed++;
    checks++;
    if (obs_retire !== 1 || obs_retire_cyc !== 0)
      $display("FAIL alu_retire got %0d@%0d exp 1@0", obs_retire, obs_retire_cyc);
    else passed++;
    checks++;
    if (obs_wb.alu_result !== 32'h1234 || obs_wb.rd !== 5'd5 || obs_wb.pc_inc !== 32'h40)
      $display("FAIL alu_fields got %h/%0d/%h exp 00001234/5/00000040",
               obs_wb.alu_result, obs_wb.rd, obs_wb.pc_inc);
    else passed++;
  endtask

  task automatic test_sb();
    exe_mem_inf_t op;
    op = '0;
    op.alu_result = 32'h1003;
    op.write_data = 32'h000000AB;
    op.ctrl.mem_store = 1;
    run_op(op, F3_LB, 0, 0);
    checks++;
    if (obs_timeout) $display("FAIL sb_timeout got 1 exp 0");
    else passed++;
    checks++;
    if (obs_be !== 4'b1000 || obs_we !== 1'b1)
      $display("FAIL sb_be_we got %b/%b exp 1000/1", obs_be, obs_we);
    else passed++;
    checks++;
    if (obs_wdata !== 32'hABABABAB || obs_addr !== 32'h1000)
      $display("FAIL sb_data_addr got %h/%h exp ababababa/00001000", obs_wdata, obs_addr);
    else passed++;
    checks++;
    if (obs_stall !== 2 || obs_hs !== 1 || obs_retire !== 0)
      $display("FAIL sb_timing got stall %0d hs %0d ret %0d exp 2 1 0",
               obs_stall, obs_hs, obs_retire);
    else passed++;
  endtask

  task automatic test_load_ext();
    exe_mem_inf_t op;
    logic [2:0]   fns [3];
    logic [31:0]  exps [3];
    fns[0] = F3_LB;  exps[0] = 32'hFFFFFF80;
    fns[1] = F3_LBU; exps[1] = 32'h00000080;
    fns[2] = F3_LH;  exps[2] = 32'h00000080;
    for (int i = 0; i < 3; i++) begin
      bus_mem[0] = 32'h00800000;
      op = '0;
      op.alu_result = 32'h2002;
      op.rd = 5'd9;
      op.ctrl.mem_load = 1;
      op.ctrl.register_write = 1;
      op.ctrl.result_src = 2'd1;
      run_op(op, fns[i], 0, 0);
      checks++;
      if (obs_retire !== 1 || obs_wb.read_data !== exps[i])
        $display("FAIL load_ext%0d got %0d:%h exp 1:%h",
                 i, obs_retire, obs_wb.read_data, exps[i]);
      else passed++;
      checks++;
      if (obs_stall !== 3 || obs_we !== 1'b0 || obs_addr !== 32'h2000)
        $display("FAIL load_ext%0d_bus got %0d/%b/%h exp 3/0/00002000",
                 i, obs_stall, obs_we, obs_addr);
      else passed++;
    end
  endtask

  task automatic test_sw_wait();
    exe_mem_inf_t op;
    op = '0;
    op.alu_result = 32'h1008;
    op.write_data = 32'hDEADBEEF;
    op.ctrl.mem_store = 1;
    run_op(op, F3_LW, 3, 0);
    checks++;
    if (obs_stall !== 5 || obs_hs !== 1)
      $display("FAIL sw_wait got stall %0d hs %0d exp 5 1", obs_stall, obs_hs);
    else passed++;
    checks++;
    if (obs_stable !== 1'b1) $display("FAIL sw_stable got 0 exp 1");
    else passed++;
    checks++;
    if (obs_addr !== 32'h1008 || obs_wdata !== 32'hDEADBEEF || obs_be !== 4'hF)
      $display("FAIL sw_fields got %h/%h/%b exp 00001008/deadbeef/1111",
               obs_addr, obs_wdata, obs_be);
    else passed++;
  endtask

  task automatic test_reset_mid_access();
    exe_mem_inf_t op;
    op = '0;
    op.alu_result = 32'h104;
    op.rd = 5'd7;
    op.ctrl.mem_load = 1;
    op.ctrl.register_write = 1;
    @(negedge clk);
    exe = op;
    f3 = F3_LW;
    req_ready = 1;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    #1;
    checks++;
    if (dut.state_q !== RSP) $display("FAIL mid_in_rsp got %0d exp %0d", dut.state_q, RSP);
    else passed++;
    rst = 1;
    exe = '0;
    req_ready = 0;
    @(posedge clk);
    @(negedge clk);
    rst = 0;
    rsp_valid = 1;
    rdata = 32'h5555AAAA;
    #1;
    checks++;
    if (dut.state_q !== IDLE || stall !== 1'b0 || req_valid !== 1'b0)
      $display("FAIL mid_reset got st %0d stall %b req %b exp %0d 0 0",
               dut.state_q, stall, req_valid, IDLE);
    else passed++;
    @(posedge clk);
    #1;
    rsp_valid = 0;
    checks++;
    if (dut.state_q !== IDLE || wb.register_write !== 1'b0)
      $display("FAIL mid_ignore got st %0d rw %b exp %0d 0",
               dut.state_q, wb.register_write, IDLE);
    else passed++;
    bus_mem[3] = 32'h13572468;
    op.alu_result = 32'h10C;
    run_op(op, F3_LW, 0, 1);
    checks++;
    if (obs_retire !== 1 || obs_wb.read_data !== 32'h13572468)
      $display("FAIL mid_next_load got %0d:%h exp 1:13572468",
               obs_retire, obs_wb.read_data);
    else passed++;
  endtask

  task automatic test_back_to_back();
    exe_mem_inf_t op;
    bus_mem[4] = 32'hCAFEF00D;
    op = '0;
    op.alu_result = 32'h110;
    op.rd = 5'd3;
    op.ctrl.mem_load = 1;
    op.ctrl.register_write = 1;
    run_op(op, F3_LW, 0, 0);
    checks++;
    if (obs_retire !== 1 || obs_hs !== 1 || obs_wb.read_data !== 32'hCAFEF00D)
      $display("FAIL b2b_lw got ret %0d hs %0d data %h exp 1 1 cafef00d",
               obs_retire, obs_hs, obs_wb.read_data);
    else passed++;
    op = '0;
    op.alu_result = 32'h114;
    op.write_data = 32'h0BADC0DE;
    op.ctrl.mem_store = 1;
    run_op(op, F3_LW, 0, 0);
    checks++;
    if (obs_first_req !== 1 || obs_hs !== 1 || obs_retire !== 0)
      $display("FAIL b2b_sw got req@%0d hs %0d ret %0d exp 1 1 0",
               obs_first_req, obs_hs, obs_retire);
    else passed++;
    checks++;
    if (bus_mem[5] !== 32'h0BADC0DE)
      $display("FAIL b2b_sw_mem got %h exp 0badc0de", bus_mem[5]);
    else passed++;
  endtask

  task automatic test_random();
    for (int w = 0; w < 16; w++) begin
      bus_mem[w] = $urandom;
      for (int b = 0; b < 4; b++) ref_mem[4*w+b] = bus_mem[w][8*b +: 8];
    end
    for (int n = 0; n < 40; n++) begin
      exe_mem_inf_t op;
      int           kind, size, nb, ea, rdly, sdly, exp_stall;
      logic [31:0]  a;
      logic [31:0]  exp_wd;
      logic [31:0]  exp_rd;
      logic [3:0]   exp_be;
      logic [2:0]   fn;
      longint       v;
      kind = $urandom_range(0, 2);
      size = $urandom_range(0, 2);
      nb   = 1 << size;
      a    = 32'h100 + ($urandom_range(0, 63) & ~(nb - 1));
      ea   = int'(a & 32'd63);
      fn   = 3'(size);
      if (kind == 1 && size < 2 && $urandom_range(0, 1) == 1) fn[2] = 1'b1;
      rdly = $urandom_range(0, 3);
      sdly = $urandom_range(0, 2);
      op = '0;
      op.write_data = $urandom;
      op.rd = 5'($urandom_range(1, 31));
      op.pc_inc = $urandom;
      if (kind == 0) begin
        op.alu_result = $urandom;
        op.ctrl.register_write = 1;
      end else begin
        op.alu_result = a;
        op.ctrl.mem_load = (kind == 1);
        op.ctrl.mem_store = (kind == 2);
        op.ctrl.register_write = (kind == 1);
        op.ctrl.result_src = (kind == 1) ? 2'd1 : 2'd0;
      end
      exp_be = 4'(((1 << nb) - 1) << (a % 4));
      case (size)
        0:       exp_wd = {24'h0, op.write_data[7:0]} * 32'h01010101;
        1:       exp_wd = {16'h0, op.write_data[15:0]} * 32'h00010001;
        default: exp_wd = op.write_data;
      endcase
      v = 0;
      for (int b = 0; b < nb; b++) v = v | (longint'(ref_mem[ea+b]) << (8*b));
      if (!fn[2] && nb < 4 && v[8*nb-1]) v = v | ~((64'd1 << (8*nb)) - 1);
      exp_rd = v[31:0];
      exp_stall = (kind == 0) ? 0 : (kind == 2) ? rdly + 2 : rdly + sdly + 3;
      run_op(op, fn, rdly, sdly);
      checks++;
      if (obs_timeout || obs_stall !== exp_stall)
        $display("FAIL rnd%0d_stall got %0d (to %b) exp %0d", n, obs_stall, obs_timeout, exp_stall);
      else passed++;
      checks++;
      if (obs_hs !== ((kind == 0) ? 0 : 1))
        $display("FAIL rnd%0d_hs got %0d exp %0d", n, obs_hs, (kind == 0) ? 0 : 1);
      else passed++;
      checks++;
      if (obs_retire !== ((kind == 2) ? 0 : 1))
        $display("FAIL rnd%0d_retire got %0d exp %0d", n, obs_retire, (kind == 2) ? 0 : 1);
      else passed++;
      if (kind == 0) begin
        checks++;
        if (obs_wb.alu_result !== op.alu_result || obs_wb.rd !== op.rd ||
            obs_wb.pc_inc !== op.pc_inc || obs_wb.result_src !== 2'd0)
          $display("FAIL rnd%0d_alu got %h/%0d/%h exp %h/%0d/%h", n, obs_wb.alu_result,
                   obs_wb.rd, obs_wb.pc_inc, op.alu_result, op.rd, op.pc_inc);
        else passed++;
      end else begin
        checks++;
        if (obs_addr !== (a & ~32'd3) || obs_be !== exp_be || obs_we !== (kind == 2))
          $display("FAIL rnd%0d_req got %h/%b/%b exp %h/%b/%b", n, obs_addr, obs_be,
                   obs_we, a & ~32'd3, exp_be, kind == 2);
        else passed++;
      end
      if (kind == 1) begin
        checks++;
        if (obs_wb.read_data !== exp_rd || obs_wb.rd !== op.rd || obs_wb.result_src !== 2'd1)
          $display("FAIL rnd%0d_load got %h rd %0d exp %h rd %0d",
                   n, obs_wb.read_data, obs_wb.rd, exp_rd, op.rd);
        else passed++;
      end
      if (kind == 2) begin
        checks++;
        if (obs_wdata !== exp_wd)
          $display("FAIL rnd%0d_wdata got %h exp %h", n, obs_wdata, exp_wd);
        else passed++;
        for (int b = 0; b < nb; b++) ref_mem[ea+b] = op.write_data[8*b +: 8];
      end
    end
  endtask

  initial begin
    rst = 1;
    exe = '0;
    f3 = 3'b0;
    req_ready = 0;
    rsp_valid = 0;
    rdata = '0;
    for (int w = 0; w < 16; w++) bus_mem[w] = '0;
    test_reset();
    test_alu_op();
    test_sb();
    test_load_ext();
    test_sw_wait();
    test_reset_mid_access();
    test_back_to_back();
    test_random();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

endmodule
